// File: rtl/spi_master_mcs.sv
// spi_master_mcs: SPI master with run-time mode, internal chip-select timing and multi-word bursts under one CS.
module spi_master_mcs #(
    parameter int DATA_WIDTH        = 8,
    parameter int NUM_CS            = 4,
    parameter int CLKS_PER_HALF_BIT = 200,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_HOLD_CLKS      = 2,
    parameter int CS_IDLE_CLKS      = 3,
    parameter bit MSB_FIRST         = 1,
    localparam int CSW              = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [1:0]            i_SPI_Mode,
    input  logic [CSW-1:0]        i_CS_Sel,
    input  logic [DATA_WIDTH-1:0] i_TX_Word,
    input  logic                  i_TX_DV,
    input  logic                  i_TX_Last,
    output logic                  o_TX_Ready,
    output logic                  o_RX_DV,
    output logic [DATA_WIDTH-1:0] o_RX_Word,
    output logic                  o_Busy,
    output logic                  o_SPI_Clk,
    input  logic                  i_SPI_MISO,
    output logic                  o_SPI_MOSI,
    output logic [NUM_CS-1:0]     o_SPI_CS_n
);
    localparam int EW = $clog2(2 * DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD, GAP} state_t;

    state_t                state;
    logic [31:0]           cnt;
    logic [EW-1:0]         ecnt;
    logic [DATA_WIDTH-1:0] tx_sh, rx_sh, word_sh, tx_next, rx_next;
    logic [1:0]            mode;
    logic                  last, done;
    logic                  accept, cpha_a, word_bit, tx_bit, toggle, lead, fin;

    always_comb begin
        accept   = i_TX_DV & o_TX_Ready;
        cpha_a   = (state == IDLE) ? i_SPI_Mode[0] : mode[0];
        word_bit = MSB_FIRST ? i_TX_Word[DATA_WIDTH-1] : i_TX_Word[0];
        word_sh  = MSB_FIRST ? i_TX_Word << 1 : i_TX_Word >> 1;
        tx_bit   = MSB_FIRST ? tx_sh[DATA_WIDTH-1] : tx_sh[0];
        tx_next  = MSB_FIRST ? tx_sh << 1 : tx_sh >> 1;
        rx_next  = MSB_FIRST ? {rx_sh[DATA_WIDTH-2:0], i_SPI_MISO} : {i_SPI_MISO, rx_sh[DATA_WIDTH-1:1]};
        toggle   = cnt == 32'(CLKS_PER_HALF_BIT - 1);
        lead     = ~ecnt[0];
        fin      = ecnt == EW'(2 * DATA_WIDTH - 1);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ecnt       <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            mode       <= '0;
            last       <= 1'b0;
            done       <= 1'b0;
            o_TX_Ready <= 1'b0;
            o_RX_DV    <= 1'b0;
            o_RX_Word  <= '0;
            o_Busy     <= 1'b0;
            o_SPI_Clk  <= 1'b0;
            o_SPI_MOSI <= 1'b0;
            o_SPI_CS_n <= '1;
        end else begin
            o_RX_DV <= 1'b0;
            cnt     <= cnt + 32'd1;
            // With CPHA=0 the first bit must already be on MOSI before the first leading edge
            if (accept) begin
                last       <= i_TX_Last;
                tx_sh      <= cpha_a ? i_TX_Word : word_sh;
                o_SPI_MOSI <= cpha_a ? o_SPI_MOSI : word_bit;
                cnt        <= '0;
                ecnt       <= '0;
                done       <= 1'b0;
                o_TX_Ready <= 1'b0;
                o_Busy     <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SETUP;
                        mode       <= i_SPI_Mode;
                        o_SPI_Clk  <= i_SPI_Mode[1];
                        o_SPI_CS_n <= ~(NUM_CS'(1) << i_CS_Sel);
                    end else begin
                        o_TX_Ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == 32'(CS_SETUP_CLKS - 1)) begin
                        state <= XFER;
                        cnt   <= '0;
                    end
                end
                XFER: begin
                    if (done) begin
                        state      <= last ? HOLD : WAIT;
                        o_TX_Ready <= ~last;
                        o_RX_DV    <= 1'b1;
                        o_RX_Word  <= rx_sh;
                        cnt        <= '0;
                    end else if (toggle) begin
                        cnt       <= '0;
                        ecnt      <= ecnt + 1'b1;
                        done      <= fin;
                        o_SPI_Clk <= ~o_SPI_Clk;
                        if (lead ^ mode[0])
                            rx_sh <= rx_next;
                        if (mode[0] ? lead : !lead && !fin) begin
                            o_SPI_MOSI <= tx_bit;
                            tx_sh      <= tx_next;
                        end
                    end
                end
                WAIT: begin
                    if (accept)
                        state <= XFER;
                end
                HOLD: begin
                    o_SPI_Clk <= mode[1];
                    if (cnt == 32'(CS_HOLD_CLKS - 1)) begin
                        state      <= GAP;
                        cnt        <= '0;
                        o_SPI_CS_n <= '1;
                    end
                end
                GAP: begin
                    if (cnt == 32'(CS_IDLE_CLKS - 1)) begin
                        state      <= IDLE;
                        o_Busy     <= 1'b0;
                        o_TX_Ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_mcs.sv
// tb_spi_master_mcs: directed checks of spi_master_mcs with MISO looped back from MOSI.
module tb_spi_master_mcs;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] spi_mode = '0;
    logic [1:0] cs_sel = '0;
    logic [7:0] tx_word = '0;
    logic       tx_dv = 1'b0;
    logic       tx_last = 1'b0;
    logic       ready, rx_dv, busy, sclk, mosi;
    logic [7:0] rx_word;
    logic [3:0] cs_n;
    logic       a_ready, a_dv, a_busy, a_sclk, a_mosi;
    logic [7:0] a_word;
    logic [2:0] a_cs;

    int n_cmp = 0;
    int n_err = 0;
    int dv_cnt = 0, rise_cnt = 0, cs_low_cnt = 0, cs_rise_cnt = 0, hi_run = 0, last_hi_run = 0;
    logic       sclk_q = 1'b0;
    logic [3:0] cs_q = 4'hF;

    always #5 clk = ~clk;

    spi_master_mcs #(
        .DATA_WIDTH(8), .NUM_CS(4), .CLKS_PER_HALF_BIT(2),
        .CS_SETUP_CLKS(2), .CS_HOLD_CLKS(2), .CS_IDLE_CLKS(3), .MSB_FIRST(1)
    ) u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Mode(spi_mode), .i_CS_Sel(cs_sel),
        .i_TX_Word(tx_word), .i_TX_DV(tx_dv), .i_TX_Last(tx_last),
        .o_TX_Ready(ready), .o_RX_DV(rx_dv), .o_RX_Word(rx_word), .o_Busy(busy),
        .o_SPI_Clk(sclk), .i_SPI_MISO(mosi), .o_SPI_MOSI(mosi), .o_SPI_CS_n(cs_n)
    );

    // Second instance: 3 chip selects so index 3 is out of range, and LSb-first ordering
    spi_master_mcs #(
        .DATA_WIDTH(8), .NUM_CS(3), .CLKS_PER_HALF_BIT(2),
        .CS_SETUP_CLKS(2), .CS_HOLD_CLKS(2), .CS_IDLE_CLKS(3), .MSB_FIRST(0)
    ) u_aux (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Mode(spi_mode), .i_CS_Sel(cs_sel),
        .i_TX_Word(tx_word), .i_TX_DV(tx_dv), .i_TX_Last(tx_last),
        .o_TX_Ready(a_ready), .o_RX_DV(a_dv), .o_RX_Word(a_word), .o_Busy(a_busy),
        .o_SPI_Clk(a_sclk), .i_SPI_MISO(a_mosi), .o_SPI_MOSI(a_mosi), .o_SPI_CS_n(a_cs)
    );

    always @(posedge clk) begin
        if (rx_dv) dv_cnt++;
        if (sclk && !sclk_q) rise_cnt++;
        if (cs_n != 4'hF) begin
            cs_low_cnt++;
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end else begin
            hi_run++;
        end
        if (cs_n == 4'hF && cs_q != 4'hF) cs_rise_cnt++;
        sclk_q = sclk;
        cs_q   = cs_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(ready), 1);
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        while (!rx_dv && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("dv_wait", 32'(rx_dv), 1);
    endtask

    task automatic send(input logic [1:0] m, input logic [1:0] s, input logic [7:0] w, input logic l);
        int n;
        wait_ready(n);
        spi_mode = m;
        cs_sel   = s;
        tx_word  = w;
        tx_last  = l;
        tx_dv    = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
    endtask

    initial begin
        int n, b_dv, b_rise, b_low, b_csr;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_dv", 32'(rx_dv), 0);
        check("rst_word", 32'(rx_word), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_cs", 32'(cs_n), 32'hF);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_rise", 32'(ready), 1);

        b_dv = dv_cnt; b_rise = rise_cnt; b_low = cs_low_cnt;
        send(2'd0, 2'd1, 8'hA5, 1'b1);
        check("s1_cs", 32'(cs_n), 32'hD);
        check("s1_busy", 32'(busy), 1);
        check("s1_ready", 32'(ready), 0);
        repeat (3) @(negedge clk);
        check("s1_sclk_pre", 32'(sclk), 0);
        @(negedge clk);
        check("s1_sclk_first", 32'(sclk), 1);
        wait_dv(n);
        check("s1_rx", 32'(rx_word), 32'hA5);
        wait_ready(n);
        check("s1_gap", 32'(n), 5);
        check("s1_dv_count", 32'(dv_cnt - b_dv), 1);
        check("s1_rises", 32'(rise_cnt - b_rise), 8);
        check("s1_cs_low", 32'(cs_low_cnt - b_low), 37);

        for (int m = 1; m < 4; m++) begin
            send(2'(m), 2'd0, 8'h3C, 1'b1);
            check($sformatf("m%0d_cs", m), 32'(cs_n), 32'hE);
            check($sformatf("m%0d_cpol", m), 32'(sclk), 32'(m >> 1));
            repeat (3) @(negedge clk);
            check($sformatf("m%0d_mosi_pre", m), 32'(mosi), 32'(m == 1));
            @(negedge clk);
            check($sformatf("m%0d_sclk_lead", m), 32'(sclk), 32'(((m >> 1) & 1) ^ 1));
            check($sformatf("m%0d_mosi_lead", m), 32'(mosi), 0);
            wait_dv(n);
            check($sformatf("m%0d_rx", m), 32'(rx_word), 32'h3C);
            wait_ready(n);
            check($sformatf("m%0d_idle_pol", m), 32'(sclk), 32'(m >> 1));
        end

        b_dv = dv_cnt; b_rise = rise_cnt; b_csr = cs_rise_cnt;
        send(2'd0, 2'd2, 8'h01, 1'b0);
        wait_dv(n);
        check("b_rx0", 32'(rx_word), 32'h01);
        check("b_ready_with_dv", 32'(ready), 1);
        send(2'd0, 2'd3, 8'h80, 1'b0);
        check("b_cs_kept", 32'(cs_n), 32'hB);
        @(negedge clk);
        check("b_sclk_w2", 32'(sclk), 0);
        @(negedge clk);
        check("b_sclk_w3", 32'(sclk), 1);
        wait_dv(n);
        check("b_rx1", 32'(rx_word), 32'h80);
        send(2'd3, 2'd0, 8'hFF, 1'b1);
        wait_dv(n);
        check("b_rx2", 32'(rx_word), 32'hFF);
        check("b_cs_last", 32'(cs_n), 32'hB);
        wait_ready(n);
        check("b_dv_count", 32'(dv_cnt - b_dv), 3);
        check("b_rises", 32'(rise_cnt - b_rise), 24);
        check("b_cs_rises", 32'(cs_rise_cnt - b_csr), 1);

        wait_ready(n);
        b_dv = dv_cnt;
        spi_mode = 2'd0; cs_sel = 2'd0; tx_word = 8'h55; tx_last = 1'b1; tx_dv = 1'b1;
        @(negedge clk);
        check("h_cs1", 32'(cs_n), 32'hE);
        wait_dv(n);
        check("h_rx1", 32'(rx_word), 32'h55);
        wait_ready(n);
        check("h_gap", 32'(n), 5);
        check("h_dv1", 32'(dv_cnt - b_dv), 1);
        @(negedge clk);
        tx_dv = 1'b0;
        check("h_cs2", 32'(cs_n), 32'hE);
        check("h_busy2", 32'(busy), 1);
        check("h_ready2", 32'(ready), 0);
        wait_dv(n);
        check("h_cs_high_run", 32'(last_hi_run), 4);
        check("h_rx2", 32'(rx_word), 32'h55);
        wait_ready(n);
        check("h_dv2", 32'(dv_cnt - b_dv), 2);

        send(2'd0, 2'd3, 8'h01, 1'b1);
        check("oor_main_cs", 32'(cs_n), 32'h7);
        check("oor_aux_cs", 32'(a_cs), 32'h7);
        check("lsb_first_mosi", 32'(a_mosi), 1);
        check("msb_first_mosi", 32'(mosi), 0);
        repeat (8) @(negedge clk);
        check("oor_aux_cs_mid", 32'(a_cs), 32'h7);
        wait_dv(n);
        check("lsb_dv", 32'(a_dv), 1);
        check("lsb_rx", 32'(a_word), 32'h01);
        check("msb_rx", 32'(rx_word), 32'h01);
        wait_ready(n);

        b_dv = dv_cnt;
        send(2'd2, 2'd1, 8'hC3, 1'b1);
        repeat (11) @(negedge clk);
        check("r_cs_pre", 32'(cs_n), 32'hD);
        check("r_sclk_pre", 32'(sclk), 1);
        rst = 1'b1;
        @(negedge clk);
        check("r_cs", 32'(cs_n), 32'hF);
        check("r_sclk", 32'(sclk), 0);
        check("r_busy", 32'(busy), 0);
        check("r_ready", 32'(ready), 0);
        check("r_mosi", 32'(mosi), 0);
        check("r_word", 32'(rx_word), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("r_no_dv", 32'(dv_cnt - b_dv), 0);
        send(2'd0, 2'd1, 8'h96, 1'b1);
        wait_dv(n);
        check("r_rx_after", 32'(rx_word), 32'h96);
        wait_ready(n);
        check("r_dv_after", 32'(dv_cnt - b_dv), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
